systolic_matmul_engine: RTL

SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

---
 rtl/systolic_matmul_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_engine.sv
// Output-stationary DIM x DIM systolic array computing M = A*B (+ C).
// Operands arrive one unskewed beat per step; skewing and draining are internal.
module systolic_matmul_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int DIM        = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [DIM*DIM*BUS_WIDTH-1:0]  c_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DIM*DATA_WIDTH-1:0]     a_col_i,
  input  logic [DIM*DATA_WIDTH-1:0]     b_row_i,
  output logic                          busy_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [DIM*DIM*BUS_WIDTH-1:0]  res_o,
  output logic [DIM*DIM-1:0]            ovf_o,
  output logic [$clog2(3*DIM-1)-1:0]    step_o
);

  localparam int SW = $clog2(3*DIM-1);
  localparam logic [SW-1:0] FEED_LAST = SW'(DIM-1);
  localparam logic [SW-1:0] LAST_STEP = SW'(3*DIM-2);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e state_q, state_d;
  logic   step_en, start_acc, done_load;

  logic [SW-1:0]                 step_q;
  logic                          mode_q;
  logic [DIM*DIM*BUS_WIDTH-1:0]  c_q, res_q, res_d;
  logic [DIM*DIM-1:0]            ovf_q, ovf_d, step_ovf;

  logic signed [DATA_WIDTH-1:0] a_src    [DIM];
  logic signed [DATA_WIDTH-1:0] b_src    [DIM];
  logic signed [DATA_WIDTH-1:0] a_skew_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] b_skew_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] a_pipe_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] b_pipe_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] a_west   [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] b_north  [DIM][DIM];
  logic signed [BUS_WIDTH-1:0]  acc_q    [DIM][DIM];
  logic signed [BUS_WIDTH-1:0]  acc_nxt  [DIM][DIM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    step_en   = 1'b0;
    start_acc = 1'b0;
    done_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = FEED;
        end
      end
      FEED: begin
        if (in_valid_i) begin
          step_en = 1'b1;
          if (step_q == FEED_LAST) begin
            if (DIM == 1) begin
              state_d   = DONE;
              done_load = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // The final drain cycle adds C and captures the result without stepping.
        if (step_q == LAST_STEP) begin
          state_d   = DONE;
          done_load = 1'b1;
        end else begin
          step_en = 1'b1;
        end
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [BUS_WIDTH-1:0]    prod_ext, acc_eff, addend, sum;
    prod     = '0;
    prod_ext = '0;
    acc_eff  = '0;
    addend   = '0;
    sum      = '0;
    res_d    = res_q;
    ovf_d    = ovf_q;
    step_ovf = '0;
    for (int i = 0; i < DIM; i++) begin
      a_src[i] = (state_q == FEED) ? a_col_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_src[i] = (state_q == FEED) ? b_row_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        a_west[i][j] = (j == 0)
          ? ((i == 0) ? a_src[i] : a_skew_q[i][(i == 0) ? 0 : i-1])
          : a_pipe_q[i][(j == 0) ? 0 : j-1];
        b_north[i][j] = (i == 0)
          ? ((j == 0) ? b_src[j] : b_skew_q[j][(j == 0) ? 0 : j-1])
          : b_pipe_q[(i == 0) ? 0 : i-1][j];
        prod     = a_west[i][j] * b_north[i][j];
        prod_ext = BUS_WIDTH'(prod);
        acc_nxt[i][j] = acc_q[i][j] + prod_ext;
        step_ovf[i*DIM+j] = (acc_q[i][j][BUS_WIDTH-1] == prod_ext[BUS_WIDTH-1]) &&
                            (acc_nxt[i][j][BUS_WIDTH-1] != acc_q[i][j][BUS_WIDTH-1]);
        acc_eff = step_en ? acc_nxt[i][j] : acc_q[i][j];
        addend  = mode_q ? c_q[(i*DIM+j)*BUS_WIDTH +: BUS_WIDTH] : '0;
        sum     = acc_eff + addend;
        if (done_load) begin
          res_d[(i*DIM+j)*BUS_WIDTH +: BUS_WIDTH] = sum;
          ovf_d[i*DIM+j] = ovf_q[i*DIM+j] |
                           ((acc_eff[BUS_WIDTH-1] == addend[BUS_WIDTH-1]) &&
                            (sum[BUS_WIDTH-1] != acc_eff[BUS_WIDTH-1]));
        end
      end
    end
    if (step_en) ovf_d = ovf_d | step_ovf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q <= '0;
      mode_q <= 1'b0;
      c_q    <= '0;
      res_q  <= '0;
      ovf_q  <= '0;
      // NOTE: the register arrays are reset deliberately; a product abandoned
      // by reset must not leak stale partial sums into the next one.
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          a_skew_q[i][j] <= '0;
          b_skew_q[i][j] <= '0;
          a_pipe_q[i][j] <= '0;
          b_pipe_q[i][j] <= '0;
          acc_q[i][j]    <= '0;
        end
      end
    end else if (start_acc) begin
      step_q <= '0;
      mode_q <= mode_i;
      c_q    <= c_i;
      res_q  <= '0;
      ovf_q  <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          a_skew_q[i][j] <= '0;
          b_skew_q[i][j] <= '0;
          a_pipe_q[i][j] <= '0;
          b_pipe_q[i][j] <= '0;
          acc_q[i][j]    <= '0;
        end
      end
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
      if (step_en) begin
        step_q <= step_q + 1'b1;
        for (int i = 0; i < DIM; i++) begin
          for (int d = 0; d < DIM; d++) begin
            a_skew_q[i][d] <= (d == 0) ? a_src[i] : a_skew_q[i][(d == 0) ? 0 : d-1];
            b_skew_q[i][d] <= (d == 0) ? b_src[i] : b_skew_q[i][(d == 0) ? 0 : d-1];
          end
        end
        for (int i = 0; i < DIM; i++) begin
          for (int j = 0; j < DIM; j++) begin
            a_pipe_q[i][j] <= a_west[i][j];
            b_pipe_q[i][j] <= b_north[i][j];
            acc_q[i][j]    <= acc_nxt[i][j];
          end
        end
      end
    end
  end

  assign in_ready_o  = (state_q == FEED);
  assign busy_o      = (state_q != IDLE);
  assign res_valid_o = (state_q == DONE);
  assign res_o       = res_q;
  assign ovf_o       = ovf_q;
  assign step_o      = step_q;

endmodule
